// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants for the multiplexed 7-segment display bus
//
// Purpose: symbol codes, active-low segment patterns {g,f,e,d,c,b,a} (bit0 = a)
//          and the scan-reader FSM state type. The display decoder and the
//          scan reader both use these, so the two sides agree on the table.
// Ports:   none (package).

package seg7_pkg;

    // Symbol codes carried on the recovered sym bus.
    localparam logic [3:0] SYM_S     = 4'h0;
    localparam logic [3:0] SYM_T     = 4'h1;
    localparam logic [3:0] SYM_LO    = 4'h2;   // lower-case o
    localparam logic [3:0] SYM_P     = 4'h3;
    localparam logic [3:0] SYM_G     = 4'h4;
    localparam logic [3:0] SYM_O     = 4'h5;   // upper-case O
    localparam logic [3:0] SYM_BLANK = 4'hE;
    localparam logic [3:0] SYM_BAD   = 4'hF;

    // Active-low segment patterns, {g,f,e,d,c,b,a}.
    localparam logic [6:0] PAT_S     = 7'b0010010;
    localparam logic [6:0] PAT_T     = 7'b0000111;
    localparam logic [6:0] PAT_LO    = 7'b0100011;
    localparam logic [6:0] PAT_P     = 7'b0001100;
    localparam logic [6:0] PAT_G     = 7'b0000010;
    localparam logic [6:0] PAT_O     = 7'b1000000;
    localparam logic [6:0] PAT_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWELL = 2'd1,
        HELD  = 2'd2
    } scan_state_e;

endpackage

// File: rtl/seg7_scan_reader_if.sv
// rtl/seg7_scan_reader_if.sv - multiplexed 7-segment display bus bundle
//
// Purpose: groups the active-low display bus lines.
// Signals: seg_n[6:0] segments {g..a}, dp_n decimal point, an_n[DIGITS-1:0]
//          digit enables (one-hot low when valid).
// Modports: master drives the bus (display decoder / bench),
//           slave samples it (scan reader).

interface seg7_scan_reader_if #(
    parameter int DIGITS = 4
);
    logic [6:0]        seg_n;
    logic              dp_n;
    logic [DIGITS-1:0] an_n;

    modport master (output seg_n, output dp_n, output an_n);
    modport slave  (input  seg_n, input  dp_n, input  an_n);
endinterface

// File: rtl/seg7_pattern_lookup.sv
// rtl/seg7_pattern_lookup.sv - active-low segment pattern to symbol code map
//
// Purpose: inverse of the display decoder; unknown patterns give SYM_BAD.
// Ports:   seg_n   in  7  segments {g..a}, active-low
//          code    out 4  symbol code
//          invalid out 1  pattern not in the symbol table

module seg7_pattern_lookup
    import seg7_pkg::*;
(
    input  logic [6:0] seg_n,
    output logic [3:0] code,
    output logic       invalid
);

    always_comb begin
        code    = SYM_BAD;
        invalid = 1'b0;
        case (seg_n)
            PAT_S:     code = SYM_S;
            PAT_T:     code = SYM_T;
            PAT_LO:    code = SYM_LO;
            PAT_P:     code = SYM_P;
            PAT_G:     code = SYM_G;
            PAT_O:     code = SYM_O;
            PAT_BLANK: code = SYM_BLANK;
            default: begin
                code    = SYM_BAD;
                invalid = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/seg7_scan_reader.sv
// rtl/seg7_scan_reader.sv - recovers displayed symbols from a scanned 7-seg bus
//
// Purpose: synchronizes the display bus, waits for each digit's pattern to be
//          stable for STABLE_CNT cycles, latches its symbol code and decimal
//          point, and strobes frame_valid once every digit has been accepted.
// Ports:   clk          in   1          clock
//          rst_n        in   1          asynchronous active-low reset
//          bus          slave           seg_n / dp_n / an_n display bus
//          sym          out  4*DIGITS   symbol code, digit k at [4k+3:4k]
//          dp_out       out  DIGITS     decimal point per digit, active-high
//          frame_valid  out  1          one-cycle pulse on frame completion
//          err_invalid  out  1          one-cycle pulse on unknown pattern accept

module seg7_scan_reader
    import seg7_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int STABLE_CNT  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seg7_scan_reader_if.slave     bus,
    output logic [4*DIGITS-1:0]   sym,
    output logic [DIGITS-1:0]     dp_out,
    output logic                  frame_valid,
    output logic                  err_invalid
);

    localparam int BUS_W = 8 + DIGITS;   // {an_n, dp_n, seg_n}
    localparam int CNT_W = 8;            // holds STABLE_CNT up to 255

    logic [SYNC_STAGES-1:0][BUS_W-1:0] sync_q, sync_d;
    logic [BUS_W-1:0]    prev_q, prev_d;
    scan_state_e         state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [4*DIGITS-1:0] sym_q, sym_d;
    logic [DIGITS-1:0]   dp_q, dp_d;
    logic [DIGITS-1:0]   seen_q, seen_d;
    logic                frame_valid_q, frame_valid_d;
    logic                err_invalid_q, err_invalid_d;

    logic [BUS_W-1:0]    cur;
    logic [6:0]          cur_seg;
    logic                cur_dp_n;
    logic [DIGITS-1:0]   cur_en;       // active-high digit enables
    logic                an_onehot;
    logic                bus_changed;
    logic [CNT_W-1:0]    cnt_inc;
    logic [DIGITS-1:0]   seen_next;
    logic [3:0]          lk_code;
    logic                lk_invalid;

    // Synchronizer chain; stage 0 samples the raw pins.
    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = {bus.an_n, bus.dp_n, bus.seg_n};
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    assign cur      = sync_q[SYNC_STAGES-1];
    assign cur_seg  = cur[6:0];
    assign cur_dp_n = cur[7];
    assign cur_en   = ~cur[BUS_W-1:8];
    assign prev_d   = cur;

    // Exactly one enable bit set: non-zero and clearing the lowest set bit
    // leaves nothing.
    assign an_onehot   = (cur_en != '0) && ((cur_en & (cur_en - DIGITS'(1))) == '0);
    assign bus_changed = (cur != prev_q);
    assign cnt_inc     = cnt_q + CNT_W'(1);
    assign seen_next   = seen_q | cur_en;

    seg7_pattern_lookup u_lookup (
        .seg_n   (cur_seg),
        .code    (lk_code),
        .invalid (lk_invalid)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        sym_d         = sym_q;
        dp_d          = dp_q;
        seen_d        = seen_q;
        frame_valid_d = 1'b0;
        err_invalid_d = 1'b0;

        if (!an_onehot) begin
            // Idle bus or ghosting (several anodes low): nothing to read.
            state_d = IDLE;
            cnt_d   = '0;
        end else if (bus_changed || state_q == IDLE) begin
            // The first sample of a new pattern already counts as one.
            state_d = DWELL;
            cnt_d   = CNT_W'(1);
        end else begin
            case (state_q)
                DWELL: begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_W'(STABLE_CNT)) begin
                        state_d       = HELD;
                        err_invalid_d = lk_invalid;
                        // The enable vector is one-hot here, so this loop
                        // writes exactly one digit slot.
                        for (int i = 0; i < DIGITS; i++) begin
                            if (cur_en[i]) begin
                                sym_d[4*i +: 4] = lk_code;
                                dp_d[i]         = ~cur_dp_n;
                            end
                        end
                        if (&seen_next) begin
                            frame_valid_d = 1'b1;
                            seen_d        = '0;
                        end else begin
                            seen_d = seen_next;
                        end
                    end
                end
                HELD: begin
                    state_d = HELD;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q        <= '1;
            prev_q        <= '1;
            state_q       <= IDLE;
            cnt_q         <= '0;
            sym_q         <= {DIGITS{SYM_BLANK}};
            dp_q          <= '0;
            seen_q        <= '0;
            frame_valid_q <= 1'b0;
            err_invalid_q <= 1'b0;
        end else begin
            sync_q        <= sync_d;
            prev_q        <= prev_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            sym_q         <= sym_d;
            dp_q          <= dp_d;
            seen_q        <= seen_d;
            frame_valid_q <= frame_valid_d;
            err_invalid_q <= err_invalid_d;
        end
    end

    assign sym         = sym_q;
    assign dp_out      = dp_q;
    assign frame_valid = frame_valid_q;
    assign err_invalid = err_invalid_q;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// tb/tb_seg7_scan_reader.sv - scoreboard bench for seg7_scan_reader

module tb_seg7_scan_reader;
    import seg7_pkg::*;

    localparam int DIGITS      = 4;
    localparam int STABLE_CNT  = 16;
    localparam int SYNC_STAGES = 2;
    localparam int LAT         = SYNC_STAGES + STABLE_CNT;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] sym;
    logic [3:0]  dp_out;
    logic        frame_valid;
    logic        err_invalid;

    seg7_scan_reader_if #(.DIGITS(DIGITS)) bus ();

    seg7_scan_reader #(
        .DIGITS      (DIGITS),
        .STABLE_CNT  (STABLE_CNT),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.slave),
        .sym         (sym),
        .dp_out      (dp_out),
        .frame_valid (frame_valid),
        .err_invalid (err_invalid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic        fv;
        logic        err;
        logic [15:0] sym;
        logic [3:0]  dp;
        int          cyc;
    } evt_t;

    evt_t sb[$];
    evt_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic check_eq(string tag, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Every strobe must match the oldest expected event, in content and cycle.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && (frame_valid !== 1'b0 || err_invalid !== 1'b0)) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_strobe", {30'd0, frame_valid, err_invalid}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check_eq("strobe_kind",  {30'd0, frame_valid, err_invalid}, {30'd0, mon_e.fv, mon_e.err});
                check_eq("strobe_cycle", cyc, mon_e.cyc);
                check_eq("strobe_sym",   {16'd0, sym}, {16'd0, mon_e.sym});
                check_eq("strobe_dp",    {28'd0, dp_out}, {28'd0, mon_e.dp});
            end
        end
    end

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // dig < 0 drives an idle bus.
    task automatic drive(int dig, logic [6:0] seg, logic dp, int n);
        logic [3:0] one;
        one        = 4'b0001;
        bus.an_n   = (dig < 0) ? 4'b1111 : ~(one << dig);
        bus.seg_n  = seg;
        bus.dp_n   = dp;
        step(n);
    endtask

    // Expected strobe for a pattern driven in the current cycle.
    task automatic expect_evt(logic fv, logic err, logic [15:0] s, logic [3:0] d);
        evt_t e;
        e.fv  = fv;
        e.err = err;
        e.sym = s;
        e.dp  = d;
        e.cyc = cyc + LAT;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        bus.an_n  = 4'b1111;
        bus.seg_n = PAT_BLANK;
        bus.dp_n  = 1'b1;
        rst_n     = 1'b0;
        step(2);
        rst_n     = 1'b1;
    endtask

    initial begin
        bus.an_n  = 4'b1111;
        bus.seg_n = PAT_BLANK;
        bus.dp_n  = 1'b1;
        rst_n     = 1'b0;
        step(3);
        check_eq("reset_sym", {16'd0, sym}, 32'h0000EEEE);
        check_eq("reset_dp",  {28'd0, dp_out}, 32'd0);
        check_eq("reset_strobes", {30'd0, frame_valid, err_invalid}, 32'd0);
        rst_n = 1'b1;
        step(100);
        check_eq("idle_sym", {16'd0, sym}, 32'h0000EEEE);
        check_eq("idle_dp",  {28'd0, dp_out}, 32'd0);

        // Clean "StoP" scan.
        do_reset();
        drive(0, PAT_S,  1'b1, 20);
        drive(1, PAT_T,  1'b1, 20);
        drive(2, PAT_LO, 1'b1, 20);
        expect_evt(1'b1, 1'b0, 16'h3210, 4'b0000);
        drive(3, PAT_P,  1'b1, 20);
        drive(-1, PAT_BLANK, 1'b1, 10);
        check_eq("scan_sym", {16'd0, sym}, 32'h00003210);
        check_eq("scan_dp",  {28'd0, dp_out}, 32'd0);

        // Pattern toggling faster than the stability window is never taken.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(0, (i % 2 == 1) ? PAT_T : PAT_S, 1'b1, 10);
        end
        drive(-1, PAT_BLANK, 1'b1, 20);
        check_eq("toggle_sym", {16'd0, sym}, 32'h0000EEEE);

        // One-cycle glitch inside a long "G" dwell.
        do_reset();
        drive(0, PAT_G, 1'b1, 20);
        check_eq("glitch_first_accept", {28'd0, sym[3:0]}, 32'h4);
        drive(0, PAT_O, 1'b1, 1);
        drive(0, PAT_G, 1'b1, 20);
        check_eq("glitch_after", {28'd0, sym[3:0]}, 32'h4);
        drive(-1, PAT_BLANK, 1'b1, 10);
        check_eq("glitch_sym", {16'd0, sym}, 32'h0000EEE4);

        // Unknown pattern with decimal point on digit 2.
        do_reset();
        expect_evt(1'b0, 1'b1, 16'hEFEE, 4'b0100);
        drive(2, 7'b1110000, 1'b0, 20);
        drive(-1, PAT_BLANK, 1'b1, 10);
        check_eq("invalid_code", {28'd0, sym[11:8]}, 32'hF);
        check_eq("invalid_dp",   {28'd0, dp_out}, 32'b0100);

        // Ghosting: two anodes low is ignored, then a partial "GO" scan.
        do_reset();
        bus.an_n  = 4'b1100;
        bus.seg_n = PAT_S;
        bus.dp_n  = 1'b0;
        step(30);
        check_eq("ghost_sym", {16'd0, sym}, 32'h0000EEEE);
        check_eq("ghost_dp",  {28'd0, dp_out}, 32'd0);
        drive(0, PAT_G, 1'b1, 20);
        drive(1, PAT_O, 1'b1, 20);
        drive(-1, PAT_BLANK, 1'b1, 10);
        check_eq("go_sym", {16'd0, sym}, 32'h0000EE54);

        // Reset in the middle of a frame discards the partial frame.
        do_reset();
        drive(0, PAT_S,  1'b1, 20);
        drive(1, PAT_T,  1'b1, 20);
        drive(2, PAT_LO, 1'b1, 20);
        drive(-1, PAT_BLANK, 1'b1, 5);
        check_eq("partial_sym", {16'd0, sym}, 32'h0000E210);
        rst_n = 1'b0;
        #1;
        check_eq("midreset_sym", {16'd0, sym}, 32'h0000EEEE);
        step(1);
        rst_n = 1'b1;
        drive(3, PAT_P, 1'b1, 20);
        drive(-1, PAT_BLANK, 1'b1, 10);
        check_eq("after_reset_sym", {16'd0, sym}, 32'h00003EEE);
        drive(0, PAT_S, 1'b1, 20);
        drive(1, PAT_T, 1'b1, 20);
        expect_evt(1'b1, 1'b0, 16'h3210, 4'b0000);
        drive(2, PAT_LO, 1'b1, 20);
        drive(-1, PAT_BLANK, 1'b1, 20);
        check_eq("refill_sym", {16'd0, sym}, 32'h00003210);

        check_eq("sb_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
